layer_serializer: RTL and testbench

Parallel-to-serial converter between a convolutional layer and the next layer. It accepts one vector of N_WORDS channel words per handshake from the convolutional layer's output interface (valid/ready), buffers up to two vectors (ping-pong), and streams the words one per cycle into the next layer's demanding input interface (valid/yumi). It also counts vectors per frame and flags the final word of each frame.

---
 rtl/layer_pkg.sv | 18 +
 rtl/serializer_slot.sv | 27 ++
 rtl/layer_serializer.sv | 98 +++++++++
 tb/tb_layer_serializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// layer_pkg: shared types for the layer serializer (occupancy FSM encoding, word type).
`default_nettype none

package layer_pkg;

  localparam int LAYER_WORD_SIZE = 16;

  typedef enum logic [1:0] {
    eEMPTY = 2'b00,
    eONE   = 2'b01,
    eFULL  = 2'b10
  } occ_state_e;

  typedef logic signed [LAYER_WORD_SIZE-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/serializer_slot.sv
// serializer_slot: one N_WORDS x WORD_SIZE vector register with load enable and word-select read.
`default_nettype none

module serializer_slot #(
  parameter int N_WORDS   = 256,
  parameter int WORD_SIZE = 16,
  parameter int IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                              clk_i,
  input  logic                              wr_en,
  input  logic [N_WORDS-1:0][WORD_SIZE-1:0] wr_data,
  input  logic [IDX_W-1:0]                  rd_idx,
  output logic [WORD_SIZE-1:0]              rd_data
);

  // No reset: contents are never observed until a vector has been loaded.
  logic [N_WORDS-1:0][WORD_SIZE-1:0] mem;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/layer_serializer.sv
// layer_serializer: ping-pong buffered parallel-to-serial converter with per-frame last-word flag.
`default_nettype none

module layer_serializer
  import layer_pkg::*;
#(
  parameter int N_WORDS   = 256,
  parameter int WORD_SIZE = 16,
  parameter int N_VECTORS = 64
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [N_WORDS-1:0][WORD_SIZE-1:0] data_i,
  output logic                              valid_o,
  input  logic                              yumi_i,
  output logic [WORD_SIZE-1:0]              data_o,
  output logic                              last_o
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int CNT_W = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(N_VECTORS - 1);

  occ_state_e       state, state_nxt;
  logic             wr_slot, rd_slot;
  logic [IDX_W-1:0] word_idx;
  logic [CNT_W-1:0] vec_cnt;

  logic accept, consume, release_slot;
  logic [WORD_SIZE-1:0] rd_data0, rd_data1;

  assign ready_o      = (state != eFULL);
  assign valid_o      = (state != eEMPTY);
  assign accept       = valid_i && ready_o;
  assign consume      = yumi_i && valid_o;
  assign release_slot = consume && (word_idx == LAST_IDX);

  serializer_slot #(.N_WORDS(N_WORDS), .WORD_SIZE(WORD_SIZE), .IDX_W(IDX_W)) u_slot0 (
    .clk_i  (clk_i),
    .wr_en  (accept && !wr_slot),
    .wr_data(data_i),
    .rd_idx (word_idx),
    .rd_data(rd_data0)
  );

  serializer_slot #(.N_WORDS(N_WORDS), .WORD_SIZE(WORD_SIZE), .IDX_W(IDX_W)) u_slot1 (
    .clk_i  (clk_i),
    .wr_en  (accept && wr_slot),
    .wr_data(data_i),
    .rd_idx (word_idx),
    .rd_data(rd_data1)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      eEMPTY: if (accept) state_nxt = eONE;
      eONE: begin
        // Accept and release together keep one slot occupied.
        if (accept && !release_slot)      state_nxt = eFULL;
        else if (!accept && release_slot) state_nxt = eEMPTY;
      end
      eFULL:   if (release_slot) state_nxt = eONE;
      default: state_nxt = eEMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= eEMPTY;
      wr_slot  <= 1'b0;
      rd_slot  <= 1'b0;
      word_idx <= '0;
      vec_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) wr_slot <= ~wr_slot;
      if (consume) begin
        if (release_slot) begin
          word_idx <= '0;
          rd_slot  <= ~rd_slot;
          vec_cnt  <= (vec_cnt == LAST_VEC) ? '0 : vec_cnt + 1'b1;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

  assign data_o = valid_o ? (rd_slot ? rd_data1 : rd_data0) : '0;
  assign last_o = valid_o && (word_idx == LAST_IDX) && (vec_cnt == LAST_VEC);

endmodule

`default_nettype wire

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: directed self-checking bench, N_WORDS=4, N_VECTORS=2.
`default_nettype none

module tb_layer_serializer;

  localparam int NW = 4;
  localparam int WS = 16;
  localparam int NV = 2;

  logic                   clk = 1'b0;
  logic                   reset_i = 1'b1;
  logic                   valid_i = 1'b0;
  logic                   ready_o;
  logic [NW-1:0][WS-1:0]  data_i = '0;
  logic                   valid_o;
  logic                   yumi_i = 1'b0;
  logic [WS-1:0]          data_o;
  logic                   last_o;

  int checks = 0;
  int failures = 0;

  layer_serializer #(.N_WORDS(NW), .WORD_SIZE(WS), .N_VECTORS(NV)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .valid_o(valid_o),
    .yumi_i (yumi_i),
    .data_o (data_o),
    .last_o (last_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Vector whose word k is base+k (word 0 streamed first).
  function automatic logic [NW-1:0][WS-1:0] mkvec(input logic [WS-1:0] base);
    logic [NW-1:0][WS-1:0] v;
    for (int k = 0; k < NW; k++) v[k] = base + WS'(k);
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    check({tag, "_data"},  32'(data_o),  32'd0);
    check({tag, "_last"},  32'(last_o),  32'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    yumi_i  = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  // Sends one vector with yumi held high and checks all words; exp_last flags the final word.
  task automatic stream_one(input string tag, input logic [WS-1:0] base, input logic exp_last);
    data_i  = mkvec(base);
    valid_i = 1'b1;
    yumi_i  = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < NW; k++) begin
      check({tag, "_valid"}, 32'(valid_o), 32'd1);
      check({tag, "_data"},  32'(data_o),  32'(base + WS'(k)));
      check({tag, "_last"},  32'(last_o),  32'((k == NW - 1) && exp_last));
      tick();
    end
    yumi_i = 1'b0;
    check({tag, "_drained"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    logic [15:0] pattern;
    int          exp_idx;
    int          cyc;

    tick();
    do_reset();
    check_idle("reset");

    // Single vector: word0=0x0001 .. word3=0x0004, vec_cnt=0 so no last.
    stream_one("single", 16'h0001, 1'b0);
    do_reset();
    check_idle("reset2");

    // Back-to-back frame: A then B buffered, then streamed contiguously.
    data_i  = mkvec(16'h0A00);
    valid_i = 1'b1;
    tick();
    data_i  = mkvec(16'h0B00);
    tick();
    valid_i = 1'b0;
    check("b2b_ready_full", 32'(ready_o), 32'd0);
    tick();
    tick();
    check("b2b_stall_data", 32'(data_o), 32'h0A00);
    check("b2b_stall_last", 32'(last_o), 32'd0);
    yumi_i = 1'b1;
    for (int k = 0; k < 2 * NW; k++) begin
      check("b2b_valid", 32'(valid_o), 32'd1);
      check("b2b_data",  32'(data_o),  (k < NW) ? 32'h0A00 + 32'(k) : 32'h0B00 + 32'(k - NW));
      check("b2b_last",  32'(last_o),  32'(k == 2 * NW - 1));
      check("b2b_ready", 32'(ready_o), 32'(k >= NW));
      tick();
    end
    yumi_i = 1'b0;
    check("b2b_drained", 32'(valid_o), 32'd0);

    // Simultaneous accept/release: C accepted on the edge that consumes D3.
    data_i  = mkvec(16'h0D00);
    valid_i = 1'b1;
    yumi_i  = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < NW; k++) begin
      check("sim_d_data", 32'(data_o), 32'h0D00 + 32'(k));
      check("sim_d_last", 32'(last_o), 32'd0);
      if (k == NW - 1) begin
        data_i  = mkvec(16'h0C00);
        valid_i = 1'b1;
      end
      tick();
    end
    valid_i = 1'b0;
    check("sim_c_ready", 32'(ready_o), 32'd1);
    for (int k = 0; k < NW; k++) begin
      check("sim_c_valid", 32'(valid_o), 32'd1);
      check("sim_c_data",  32'(data_o),  32'h0C00 + 32'(k));
      check("sim_c_last",  32'(last_o),  32'(k == NW - 1));
      tick();
    end
    yumi_i = 1'b0;
    check("sim_drained", 32'(valid_o), 32'd0);

    // Yumi while empty is ignored.
    yumi_i = 1'b1;
    tick();
    tick();
    yumi_i = 1'b0;
    check_idle("yumi_empty");

    // Backpressure with an irregular yumi pattern.
    data_i  = mkvec(16'h0E00);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    pattern = 16'b1011_0010_0110_1001;
    exp_idx = 0;
    cyc     = 0;
    while (exp_idx < NW && cyc < 40) begin
      check("bp_valid", 32'(valid_o), 32'd1);
      check("bp_data",  32'(data_o),  32'h0E00 + 32'(exp_idx));
      check("bp_last",  32'(last_o),  32'd0);
      yumi_i = pattern[cyc % 16];
      tick();
      if (yumi_i) exp_idx++;
      cyc++;
    end
    yumi_i = 1'b0;
    check("bp_done_in_budget", 32'(exp_idx), 32'(NW));
    check("bp_drained", 32'(valid_o), 32'd0);

    // Mid-operation reset: vec_cnt is 1 here; after reset it must restart at 0.
    data_i  = mkvec(16'h0F00);
    valid_i = 1'b1;
    yumi_i  = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    check("mid_pre_reset_data", 32'(data_o), 32'h0F02);
    do_reset();
    check_idle("mid_reset");
    stream_one("post_g", 16'h0100, 1'b0);
    stream_one("post_h", 16'h0200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
